// File: rtl/write_eeprom_if.sv
// Upstream byte-stream and i2c_master control bundle
// for the EEPROM page writer.
interface write_eeprom_if;
  logic [6:0]  slave_addr_w;
  logic [15:0] mem_addr_w;
  logic [15:0] write_nbytes_w;
  logic        start;
  logic [7:0]  data_in;
  logic        data_req;
  logic        busy;
  logic        done;
  logic [6:0]  i2c_slave_addr;
  logic        i2c_rw;
  logic [7:0]  i2c_write_data;
  logic [7:0]  i2c_nbytes;
  logic        i2c_tx_data_req;
  logic        i2c_start;

  modport slave (
    input  slave_addr_w, mem_addr_w, write_nbytes_w,
    input  start, data_in, i2c_tx_data_req,
    output data_req, busy, done,
    output i2c_slave_addr, i2c_rw, i2c_write_data,
    output i2c_nbytes, i2c_start
  );

  modport master (
    output slave_addr_w, mem_addr_w, write_nbytes_w,
    output start, data_in, i2c_tx_data_req,
    input  data_req, busy, done,
    input  i2c_slave_addr, i2c_rw, i2c_write_data,
    input  i2c_nbytes, i2c_start
  );
endinterface

// File: rtl/write_eeprom.sv
// EEPROM page writer: splits a byte stream into
// page-aligned I2C write transactions via i2c_master.
module write_eeprom #(
  parameter int PAGE_SIZE        = 64,
  parameter int WRITE_CYCLE_CLKS = 300000
) (
  input  logic         clk,
  input  logic         reset,
  write_eeprom_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, SETUP, ISSUE, SEND, DRAIN, WAIT_WR, FINISH
  } state_t;

  localparam int CW = $clog2(WRITE_CYCLE_CLKS + 1);
  localparam logic [15:0] PMASK = 16'(PAGE_SIZE - 1);
  localparam logic [15:0] PSIZE = 16'(PAGE_SIZE);
  localparam logic [CW-1:0] WLAST =
    CW'(WRITE_CYCLE_CLKS - 1);

  state_t      state;
  state_t      state_nx;
  logic        start_q;
  logic [2:0]  req_sync;
  logic [6:0]  slave;
  logic [15:0] addr;
  logic [15:0] remaining;
  logic [7:0]  chunk_len;
  logic [7:0]  idx;
  logic [7:0]  wdata;
  logic [7:0]  nbytes;
  logic        dreq;
  logic [CW-1:0] wait_cnt;

  logic        start_edge;
  logic        req_rise;
  logic        req_fall;
  logic        last_byte;
  logic        wait_done;
  logic [15:0] room;
  logic [7:0]  chunk_calc;
  logic [15:0] rem_after;

  assign start_edge = bus.start & ~start_q;
  assign req_rise   = req_sync[1] & ~req_sync[2];
  assign req_fall   = ~req_sync[1] & req_sync[2];
  assign room       = PSIZE - (addr & PMASK);
  assign chunk_calc = (remaining < room) ?
                      remaining[7:0] : room[7:0];
  assign rem_after  = remaining - {8'd0, chunk_len};
  assign last_byte  = dreq &&
                      (idx == chunk_len + 8'd1);
  assign wait_done  = (wait_cnt == WLAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state sequencing through chunks
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start_edge)
          state_nx = (bus.write_nbytes_w == 16'd0) ?
                     FINISH : SETUP;
      SETUP:   state_nx = ISSUE;
      ISSUE:   if (req_rise) state_nx = SEND;
      SEND:    if (last_byte) state_nx = DRAIN;
      DRAIN:
        if (req_fall || !req_sync[1])
          state_nx = WAIT_WR;
      WAIT_WR:
        if (wait_done)
          state_nx = (rem_after != 16'd0) ?
                     SETUP : FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latching, byte sequencing, tWR wait
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= 1'b0;
      req_sync  <= 3'd0;
      slave     <= 7'd0;
      addr      <= 16'd0;
      remaining <= 16'd0;
      chunk_len <= 8'd0;
      idx       <= 8'd0;
      wdata     <= 8'd0;
      nbytes    <= 8'd0;
      dreq      <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      start_q  <= bus.start;
      req_sync <= {req_sync[1:0], bus.i2c_tx_data_req};
      dreq     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            slave     <= bus.slave_addr_w;
            addr      <= bus.mem_addr_w;
            remaining <= bus.write_nbytes_w;
          end
        end
        SETUP: begin
          chunk_len <= chunk_calc;
          nbytes    <= chunk_calc + 8'd2;
          wdata     <= addr[15:8];
          idx       <= 8'd0;
        end
        SEND: begin
          if (req_rise && idx <= chunk_len) begin
            idx <= idx + 8'd1;
            if (idx == 8'd0) wdata <= addr[7:0];
            else             dreq  <= 1'b1;
          end
          if (dreq) wdata <= bus.data_in;
        end
        WAIT_WR: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_done) begin
            wait_cnt  <= '0;
            addr      <= addr + {8'd0, chunk_len};
            remaining <= rem_after;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and datapath registers
  always_comb begin
    bus.busy           = (state != IDLE);
    bus.done           = (state == FINISH);
    bus.i2c_start      = (state == ISSUE);
    bus.i2c_rw         = 1'b0;
    bus.data_req       = dreq;
    bus.i2c_slave_addr = slave;
    bus.i2c_write_data = wdata;
    bus.i2c_nbytes     = nbytes;
  end
endmodule
